// File: rtl/ace_read_responder_pkg.sv
// Shared ACE widths, response codes and the captured-response record.
// No logic; pure definitions used by the responder, its interface and IFU error handling.
// No flow control of its own.
package ace_read_responder_pkg;

    localparam int unsigned ACE_AXADDR_WIDTH = 32;
    localparam int unsigned ACE_XDATA_WIDTH  = 128;
    localparam int unsigned ACE_ID_WIDTH     = 4;
    localparam int unsigned ACE_USER_WIDTH   = 1;

    localparam logic [1:0] ACE_RRESP_OKAY   = 2'b00;
    localparam logic [1:0] ACE_RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] ACE_RRESP_SLVERR = 2'b10;
    localparam logic [1:0] ACE_RRESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ACE_ID_WIDTH-1:0]    id;
        logic [1:0]                 resp;
        logic [ACE_XDATA_WIDTH-1:0] data;
    } ace_rsp_t;

endpackage

// File: rtl/ace_if.sv
// ACE channel bundle (AR/R/AW/W/B/AC/CR/CD) with master and slave views.
// Wiring only, zero latency.
// Each channel carries its own valid/ready pair; RACK/WACK acknowledge completed transactions.
interface ace_if
    import ace_read_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ACE_AXADDR_WIDTH,
    parameter int unsigned BLOCK_SIZE = ACE_XDATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]     araddr;
    logic [ACE_ID_WIDTH-1:0]   arid;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [3:0]                arsnoop;
    logic [1:0]                ardomain;
    logic [1:0]                arbar;
    logic                      arvalid;
    logic                      arready;

    logic [ACE_ID_WIDTH-1:0]   rid;
    logic [BLOCK_SIZE-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic [ACE_USER_WIDTH-1:0] ruser;
    logic                      rvalid;
    logic                      rready;
    logic                      rack;

    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [ACE_ID_WIDTH-1:0]   awid;
    logic                      awvalid;
    logic                      awready;

    logic [BLOCK_SIZE-1:0]     wdata;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [ACE_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic [ACE_USER_WIDTH-1:0] buser;
    logic                      bvalid;
    logic                      bready;
    logic                      wack;

    logic [ADDR_WIDTH-1:0]     acaddr;
    logic [3:0]                acsnoop;
    logic [2:0]                acprot;
    logic                      acvalid;
    logic                      acready;

    logic [4:0]                crresp;
    logic                      crvalid;
    logic                      crready;

    logic [BLOCK_SIZE-1:0]     cddata;
    logic                      cdlast;
    logic                      cdvalid;
    logic                      cdready;

    modport m (
        output araddr, arid, arlen, arsize, arburst, arsnoop, ardomain, arbar, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready, rack,
        output awaddr, awid, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready, wack,
        input  acaddr, acsnoop, acprot, acvalid,
        output acready,
        output crresp, crvalid,
        input  crready,
        output cddata, cdlast, cdvalid,
        input  cdready
    );

    modport s (
        input  araddr, arid, arlen, arsize, arburst, arsnoop, ardomain, arbar, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready, rack,
        input  awaddr, awid, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready, wack,
        output acaddr, acsnoop, acprot, acvalid,
        input  acready,
        input  crresp, crvalid,
        output crready,
        input  cddata, cdlast, cdvalid,
        output cdready
    );

endinterface

// File: rtl/ace_read_responder.sv
// Memory-side ACE read responder: one AR at a time, one block read from external sync RAM, single-beat R.
// Latency AR handshake -> rvalid: 2+READ_LATENCY cycles in range, 1 cycle for DECERR.
// rdata/rresp held until rready; next AR only after RACK (arready low from accept until the cycle after RACK).
module ace_read_responder
    import ace_read_responder_pkg::*;
#(
    parameter logic [ACE_AXADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned                 MEM_SIZE     = 65536,
    parameter int unsigned                 READ_LATENCY = 0,
    localparam int unsigned BLOCK_SIZE      = ACE_XDATA_WIDTH,
    localparam int unsigned MEM_INDEX_WIDTH = $clog2(MEM_SIZE / (BLOCK_SIZE / 8))
) (
    input  logic                       clk,
    input  logic                       rst,
    ace_if.s                           mem_ace_if,
    output logic                       mem_en,
    output logic [MEM_INDEX_WIDTH-1:0] mem_index,
    input  logic [BLOCK_SIZE-1:0]      mem_rdata
);

    localparam int unsigned AW  = ACE_AXADDR_WIDTH;
    localparam int unsigned BOW = $clog2(BLOCK_SIZE / 8);

    // One extra bit so BASE_ADDR+MEM_SIZE at the top of the address map does not wrap.
    localparam logic [AW:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [AW:0] LIMIT_EXT = BASE_EXT + (AW + 1)'(MEM_SIZE);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RAM  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;
    localparam logic [2:0] ST_ACK  = 3'd4;

    logic [2:0]    state;
    logic [3:0]    lat_cnt;
    ace_rsp_t      rsp;
    logic [AW:0]   addr_ext;
    logic [AW-1:0] offset;
    logic          in_range;
    logic          ar_hs;

    assign addr_ext  = {1'b0, mem_ace_if.araddr};
    assign in_range  = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    assign offset    = mem_ace_if.araddr - BASE_ADDR;
    assign mem_index = MEM_INDEX_WIDTH'(offset >> BOW);
    assign ar_hs     = (state == ST_IDLE) && mem_ace_if.arvalid;
    assign mem_en    = ar_hs && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            rsp     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        rsp.id <= mem_ace_if.arid;
                        if (in_range) begin
                            state <= ST_RAM;
                        end else begin
                            rsp.resp <= ACE_RRESP_DECERR;
                            rsp.data <= '0;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_RAM: begin
                    rsp.data <= mem_rdata;
                    rsp.resp <= ACE_RRESP_OKAY;
                    if (READ_LATENCY == 0) begin
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= 4'(READ_LATENCY);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        lat_cnt <= '0;
                        state   <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (mem_ace_if.rready) begin
                        state <= mem_ace_if.rack ? ST_IDLE : ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (mem_ace_if.rack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_ace_if.arready = (state == ST_IDLE);
    assign mem_ace_if.rvalid  = (state == ST_RESP);
    assign mem_ace_if.rlast   = (state == ST_RESP);
    assign mem_ace_if.rid     = rsp.id;
    assign mem_ace_if.rresp   = rsp.resp;
    assign mem_ace_if.rdata   = rsp.data;
    assign mem_ace_if.ruser   = '0;

    // Write and snoop channels are parked: this port only serves fetch and boot reads.
    assign mem_ace_if.awready = 1'b0;
    assign mem_ace_if.wready  = 1'b0;
    assign mem_ace_if.bvalid  = 1'b0;
    assign mem_ace_if.bid     = '0;
    assign mem_ace_if.bresp   = '0;
    assign mem_ace_if.buser   = '0;
    assign mem_ace_if.acvalid = 1'b0;
    assign mem_ace_if.acaddr  = '0;
    assign mem_ace_if.acsnoop = '0;
    assign mem_ace_if.acprot  = '0;
    assign mem_ace_if.crready = 1'b1;
    assign mem_ace_if.cdready = 1'b1;

endmodule

// File: tb/tb_ace_read_responder.sv
// Bench for ace_read_responder: three instances (base 0 / latency 0, base 0 / latency 3, base 0xFFFF_0000 / latency 0)
// each with a behavioural sync RAM; expected responses queued at AR issue and popped at the R handshake.
module tb_ace_read_responder;
    import ace_read_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_d;
    logic        arvalid_d, rready_d, rack_d;
    logic [31:0] araddr_d;
    logic [3:0]  arid_d;
    int          sel;
    int          checks   = 0;
    int          failures = 0;
    ace_rsp_t    sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [127:0] blk(input logic [11:0] i);
        if (i == 12'd0) return 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        return {20'hB10C0, i, ~{20'h0, i}, 32'(i) * 32'h9E37_79B9, 32'h5A5A_0000 | 32'(i)};
    endfunction

    logic [2:0]   arready_a, rvalid_a, rlast_a, mem_en_a;
    logic [2:0]   awready_a, wready_a, bvalid_a, acvalid_a, crready_a, cdready_a;
    logic [127:0] rdata_a [3];
    logic [1:0]   rresp_a [3];
    logic [3:0]   rid_a [3];
    logic [11:0]  idx_a [3];
    int           en_cnt_a [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam logic [31:0] BA = (g == 2) ? 32'hFFFF_0000 : 32'h0;
        localparam int unsigned RL = (g == 1) ? 3 : 0;

        ace_if u_if ();
        logic         mem_en_w;
        logic [11:0]  mem_index_w;
        logic [127:0] ram_q;
        int           en_cnt = 0;

        ace_read_responder #(
            .BASE_ADDR   (BA),
            .MEM_SIZE    (65536),
            .READ_LATENCY(RL)
        ) u_dut (
            .clk       (clk),
            .rst       (rst_d),
            .mem_ace_if(u_if),
            .mem_en    (mem_en_w),
            .mem_index (mem_index_w),
            .mem_rdata (ram_q)
        );

        always_ff @(posedge clk) begin
            if (mem_en_w) begin
                ram_q  <= blk(mem_index_w);
                en_cnt <= en_cnt + 1;
            end
        end

        assign u_if.araddr   = araddr_d;
        assign u_if.arid     = arid_d;
        assign u_if.arlen    = 8'd3;
        assign u_if.arsize   = 3'd4;
        assign u_if.arburst  = 2'b01;
        assign u_if.arsnoop  = '0;
        assign u_if.ardomain = '0;
        assign u_if.arbar    = '0;
        assign u_if.arvalid  = arvalid_d && (sel == g);
        assign u_if.rready   = rready_d && (sel == g);
        assign u_if.rack     = rack_d && (sel == g);
        assign u_if.awaddr   = '0;
        assign u_if.awid     = '0;
        assign u_if.awvalid  = 1'b0;
        assign u_if.wdata    = '0;
        assign u_if.wlast    = 1'b0;
        assign u_if.wvalid   = 1'b0;
        assign u_if.bready   = 1'b1;
        assign u_if.wack     = 1'b0;
        assign u_if.acready  = 1'b1;
        assign u_if.crresp   = '0;
        assign u_if.crvalid  = 1'b0;
        assign u_if.cddata   = '0;
        assign u_if.cdlast   = 1'b0;
        assign u_if.cdvalid  = 1'b0;

        assign arready_a[g] = u_if.arready;
        assign rvalid_a[g]  = u_if.rvalid;
        assign rlast_a[g]   = u_if.rlast;
        assign mem_en_a[g]  = mem_en_w;
        assign awready_a[g] = u_if.awready;
        assign wready_a[g]  = u_if.wready;
        assign bvalid_a[g]  = u_if.bvalid;
        assign acvalid_a[g] = u_if.acvalid;
        assign crready_a[g] = u_if.crready;
        assign cdready_a[g] = u_if.cdready;
        assign rdata_a[g]   = u_if.rdata;
        assign rresp_a[g]   = u_if.rresp;
        assign rid_a[g]     = u_if.rid;
        assign idx_a[g]     = mem_index_w;
        assign en_cnt_a[g]  = en_cnt;
    end

    logic         arready_o, rvalid_o, rlast_o, mem_en_o;
    logic [127:0] rdata_o;
    logic [1:0]   rresp_o;
    logic [3:0]   rid_o;
    logic [11:0]  idx_o;
    int           en_cnt_o;

    assign arready_o = arready_a[sel];
    assign rvalid_o  = rvalid_a[sel];
    assign rlast_o   = rlast_a[sel];
    assign mem_en_o  = mem_en_a[sel];
    assign rdata_o   = rdata_a[sel];
    assign rresp_o   = rresp_a[sel];
    assign rid_o     = rid_a[sel];
    assign idx_o     = idx_a[sel];
    assign en_cnt_o  = en_cnt_a[sel];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one AR on instance s, stall rready, then RACK rack_dly cycles after the R handshake.
    task automatic do_read(input int s, input logic [31:0] addr, input logic [3:0] id, input int exp_lat,
                           input int stall, input int rack_dly, input string tag);
        logic [31:0]  base;
        logic [32:0]  a_ext, lo, hi;
        logic         ok;
        logic [11:0]  idx;
        ace_rsp_t     exp_r, got;
        logic [127:0] snap;
        int           lat, en0;
        base  = (s == 2) ? 32'hFFFF_0000 : 32'h0;
        a_ext = {1'b0, addr};
        lo    = {1'b0, base};
        hi    = lo + 33'h1_0000;
        ok    = (a_ext >= lo) && (a_ext < hi);
        idx   = 12'((addr - base) >> 4);
        exp_r.id   = id;
        exp_r.resp = ok ? 2'b00 : 2'b11;
        exp_r.data = ok ? blk(idx) : '0;
        sb_q.push_back(exp_r);

        sel = s; araddr_d = addr; arid_d = id; arvalid_d = 1'b1;
        #1;
        en0 = en_cnt_o;
        check({tag, "_arready"}, arready_o, 1);
        check({tag, "_mem_en"}, mem_en_o, ok);
        if (ok) check({tag, "_index"}, idx_o, idx);
        @(negedge clk);
        arvalid_d = 1'b0;
        lat = 1;
        while (!rvalid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        snap = rdata_o;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check($sformatf("%s_stall%0d_rvalid", tag, k), rvalid_o, 1);
            check($sformatf("%s_stall%0d_rdata", tag, k), rdata_o, snap);
            check($sformatf("%s_stall%0d_arready", tag, k), arready_o, 0);
        end
        rready_d = 1'b1;
        rack_d   = (rack_dly == 0);
        got = sb_q.pop_front();
        check({tag, "_rdata"}, rdata_o, got.data);
        check({tag, "_rresp"}, rresp_o, got.resp);
        check({tag, "_rid"}, rid_o, got.id);
        check({tag, "_rlast"}, rlast_o, 1);
        @(negedge clk);
        rready_d = 1'b0;
        rack_d   = 1'b0;
        check({tag, "_rvalid_drop"}, rvalid_o, 0);
        if (rack_dly > 0) begin
            check({tag, "_ack_wait0"}, arready_o, 0);
            for (int k = 1; k < rack_dly; k++) begin
                @(negedge clk);
                check($sformatf("%s_ack_wait%0d", tag, k), arready_o, 0);
            end
            rack_d = 1'b1;
            @(negedge clk);
            rack_d = 1'b0;
        end
        check({tag, "_idle"}, arready_o, 1);
        check({tag, "_ram_reads"}, en_cnt_o - en0, ok ? 1 : 0);
    endtask

    initial begin
        int seen;
        rst_d = 1'b1; arvalid_d = 1'b0; rready_d = 1'b0; rack_d = 1'b0;
        araddr_d = '0; arid_d = '0; sel = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d_arready", s), arready_o, 1);
            check($sformatf("rst%0d_rvalid", s), rvalid_o, 0);
            check($sformatf("rst%0d_rlast", s), rlast_o, 0);
            check($sformatf("rst%0d_rdata", s), rdata_o, 0);
            check($sformatf("rst%0d_rresp", s), rresp_o, 0);
            check($sformatf("rst%0d_rid", s), rid_o, 0);
            check($sformatf("rst%0d_mem_en", s), mem_en_o, 0);
            check($sformatf("rst%0d_tie_lo", s),
                  {awready_a[s], wready_a[s], bvalid_a[s], acvalid_a[s]}, 4'b0000);
            check($sformatf("rst%0d_tie_hi", s), {crready_a[s], cdready_a[s]}, 2'b11);
        end
        rst_d = 1'b0;
        @(negedge clk);

        do_read(0, 32'h0000_0000, 4'h0, 2, 0, 0, "rd0");
        do_read(0, 32'h0000_0014, 4'h1, 2, 0, 0, "unaligned");
        do_read(0, 32'h0001_0000, 4'h2, 1, 0, 0, "oor");
        do_read(2, 32'hFFFF_FFF0, 4'h3, 2, 0, 1, "top_of_map");
        do_read(2, 32'hFFFE_FFF0, 4'h4, 1, 0, 0, "below_base");
        do_read(1, 32'h0000_0040, 4'h5, 5, 5, 4, "backpressure");

        // Reset while the latency-3 instance sits in its wait phase.
        sel = 1; araddr_d = 32'h0000_0020; arid_d = 4'h6; arvalid_d = 1'b1;
        @(negedge clk);
        arvalid_d = 1'b0;
        @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        check("midrst_rvalid", rvalid_o, 0);
        check("midrst_arready", arready_o, 1);
        rready_d = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid_o) seen++;
        end
        rready_d = 1'b0;
        check("midrst_no_beat", seen, 0);
        do_read(1, 32'h0000_0030, 4'h7, 5, 0, 0, "post_rst");

        for (int i = 0; i < 8; i++)
            do_read(0, 32'(i * 16), 4'(i + 8), 2, 0, 0, $sformatf("b2b%0d", i));

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ace_read_responder.md
Name: ace_read_responder

Overview:
- Memory-side ACE read responder: the slave end of the read channels driven by the instruction fetch unit.
- Accepts one AR request at a time and reads one cache block from a backing synchronous block RAM.
- Returns a single-beat R response, then waits for RACK before accepting the next request.
- Write, snoop and response channels are held inactive; this block serves instruction fetch and boot memory only.

Parameters:
- BASE_ADDR, 0, byte address of the first block served (must be block-aligned).
- MEM_SIZE, 65536, bytes served starting at BASE_ADDR (power of two, multiple of the block size).
- READ_LATENCY, 0, extra wait cycles inserted after the RAM's fixed 1-cycle read; 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_ace_if  ace_if.s  -  ACE slave port; ADDR_WIDTH = ACE_AXADDR_WIDTH, BLOCK_SIZE = ACE_XDATA_WIDTH
- mem_en  out  1  backing RAM read enable
- mem_index  out  MEM_INDEX_WIDTH = $clog2(MEM_SIZE/(BLOCK_SIZE/8))  block index into the RAM
- mem_rdata  in  BLOCK_SIZE  RAM read data, valid on the cycle after mem_en

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE; arready=1; rvalid=0; rdata='0; rresp='0; rid='0; rlast=0; mem_en=0; latency counter=0.
- A request in flight when rst is asserted is dropped. No R beat is issued for it after reset.
- Tie-offs: awready=0, wready=0, bvalid=0, bid/bresp/buser='0, acvalid=0, acaddr/acsnoop/acprot='0, crready=1, cdready=1, ruser='0.
- Range check: in_range = (araddr >= BASE_ADDR) && (araddr < BASE_ADDR+MEM_SIZE). Compute it at ADDR_WIDTH+1 bits so the sum cannot wrap.
- Index: mem_index = (araddr - BASE_ADDR) >> BLOCK_OFFSET_WIDTH. Offset bits below the block are ignored, so an unaligned address returns its whole containing block.
- FSM states: IDLE, RAM, WAIT, RESP, ACK.
- IDLE:
  - arready=1.
  - On arvalid&&arready, capture arid.
  - If in_range: drive mem_en=1 and mem_index in that same cycle, then go to RAM.
  - Else: capture rresp=DECERR (2'b11) and rdata='0, then go to RESP. No RAM access.
  - arlen/arsize/arburst/arsnoop/ardomain/arbar are ignored; the response is always a single beat.
- RAM:
  - arready=0.
  - Capture mem_rdata into the rdata register; rresp=OKAY (2'b00).
  - If READ_LATENCY==0, go to RESP. Else load counter=READ_LATENCY and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 1.
- RESP:
  - rvalid=1, rlast=1, rid=captured arid.
  - rdata and rresp are held stable until rready (AXI stability rule; rvalid never drops without a handshake).
  - On rvalid&&rready: rvalid=0 next cycle.
  - If rack is also high in that same cycle, go to IDLE; else go to ACK.
- ACK: arready=0; wait for rack=1, then go to IDLE.
- RACK may arrive on the handshake cycle or any later cycle. An rack pulse outside RESP/ACK is ignored.
- Latency from AR handshake to rvalid, with rready held high:
  - 2+READ_LATENCY cycles for in-range requests.
  - 1 cycle for DECERR.
- Back-to-back rate: the next AR can be accepted the cycle after the RACK cycle.
- arready is combinationally (state==IDLE). It is registered-equivalent and has no combinational path from any input.

Decomposition:
- Shared package constants: ACE_RRESP_OKAY=2'b00, ACE_RRESP_EXOKAY=2'b01, ACE_RRESP_SLVERR=2'b10, ACE_RRESP_DECERR=2'b11. These also serve IFU error handling.
- State enum stays local to the module.
- No sub-module inside the block. The backing RAM lives outside as the existing block RAM, instantiated alongside this block in the SoC top and in the bench.

Test Plan:
- Reset then single read:
  - Stimulus: RAM block 0 = 128'h0123..EF, araddr=0x0000_0000, arid=0, rready=1, rack issued with the handshake.
  - Required: rvalid 2 cycles after the AR handshake; rdata=block 0; rresp=0; rlast=1; back in IDLE next cycle.
- Unaligned address:
  - Stimulus: araddr=0x0000_0014 with 16-byte blocks.
  - Required: mem_index=1; returns block 1.
- Out of range:
  - Stimulus: araddr=BASE_ADDR+MEM_SIZE (0x0001_0000).
  - Required: mem_en never asserted; rresp=2'b11; rdata=0; rvalid 1 cycle after the handshake.
  - Repeat with araddr=0xFFFF_FFF0 and BASE_ADDR=0xFFFF_0000: must not wrap and must return OKAY.
- Backpressure plus late RACK:
  - Stimulus: READ_LATENCY=3; rready held low 5 cycles; rack 4 cycles after the R handshake.
  - Required: rvalid at cycle 5 after AR; rdata stable while stalled; arready=0 until the cycle after rack.
- Reset mid-operation:
  - Stimulus: assert rst in the WAIT state.
  - Required: next cycle rvalid=0 and arready=1; no R beat appears later. A new AR then completes normally.
- Back-to-back:
  - Stimulus: 8 sequential ARs (0x00..0x70, step 0x10) from an IFU-style master with rack=rready&&rvalid.
  - Required: all 8 rdata values match the RAM contents in order; each AR is accepted exactly one cycle after the previous RACK.
